// File: rtl/ldpc_enc_pkg.sv
// Shared definitions for the LDPC encoder frame controller: FSM state
// encoding, default frame geometry and the encoder-side bus widths.
package ldpc_enc_pkg;

   localparam int K_DEF       = 4320;  // info bits per frame
   localparam int P_DEF       = 360;   // parity bits per frame / parallelism
   localparam int CLR_CYC_DEF = 3;     // encoder clear cycles before info phase

   localparam int CNT_W  = 13;         // info-bit counter width
   localparam int ADDR_W = 9;          // parity address width

   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_INFO,
      ST_DRAIN,
      ST_PARITY,
      ST_TAIL
   } state_e;

endpackage

// File: rtl/ldpc_enc_ctrl_if.sv
// Bit-stream interface of the frame controller: serial info bits in
// (valid/ready with a last marker) and the combined codeword stream out
// (valid only, downstream never stalls).
interface ldpc_enc_ctrl_if;

   logic s_valid;
   logic s_ready;
   logic s_data;
   logic s_last;

   logic m_valid;
   logic m_data;
   logic m_is_parity;
   logic m_last;

   // Bit source / sink side.
   modport master (
      output s_valid, s_data, s_last,
      input  s_ready,
      input  m_valid, m_data, m_is_parity, m_last
   );

   // Controller side.
   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready,
      output m_valid, m_data, m_is_parity, m_last
   );

endinterface

// File: rtl/ldpc_len_chk.sv
// Frame length checker: flags an accepted info bit whose upstream last
// marker disagrees with the controller's own view of the final index.
// The frame length itself is never changed by s_last.
module ldpc_len_chk
   import ldpc_enc_pkg::*;
#(
   parameter int K = K_DEF
) (
   input  logic accept_i,   // info bit accepted this cycle
   input  cnt_t idx_i,      // index of the bit being accepted
   input  logic last_i,     // upstream last marker
   output logic err_o       // one-cycle mismatch pulse
);

   localparam cnt_t K_LAST = cnt_t'(K - 1);

   logic is_final;

   assign is_final = (idx_i == K_LAST);
   assign err_o    = accept_i & (last_i ^ is_final);

endmodule

// File: rtl/ldpc_enc_ctrl.sv
// Frame controller for the 360-way parallel LDPC parity encoder.
// Per frame: clear the encoder, feed K info bits (echoing them as the
// systematic part), let the last XOR settle, then read the P parity bits
// out highest address first and append them to the output stream.
module ldpc_enc_ctrl
   import ldpc_enc_pkg::*;
#(
   parameter int K       = K_DEF,
   parameter int P       = P_DEF,
   parameter int CLR_CYC = CLR_CYC_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   ldpc_enc_ctrl_if.slave        bus,
   output logic                  enc_rst_n,
   output logic                  enc_din_valid,
   output logic                  enc_din,
   output cnt_t                  enc_counter,
   output addr_t                 enc_out_addr,
   output logic                  enc_check,
   input  logic                  enc_dout,
   output logic                  err_frame,
   output logic                  busy
);

   localparam int            CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);
   localparam cnt_t          K_LAST   = cnt_t'(K - 1);
   localparam addr_t         P_TOP    = addr_t'(P - 1);

   state_e           state_q, state_d;
   cnt_t             cnt_q, cnt_d;
   addr_t            addr_q, addr_d;
   logic [CLR_W-1:0] clr_q, clr_d;
   logic             sys_valid_q;
   logic             sys_data_q;

   logic             in_info;
   logic             accept;
   logic             par_valid;

   assign in_info = (state_q == ST_INFO);
   assign accept  = bus.s_valid & in_info;

   // State, info counter, parity address and clear-cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         clr_q   <= clr_d;
      end
   end

   // Systematic echo: the accepted info bit appears one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_valid_q <= 1'b0;
         sys_data_q  <= 1'b0;
      end else begin
         sys_valid_q <= accept;
         sys_data_q  <= accept & bus.s_data;
      end
   end

   // Next-state logic: frame sequencing and counter updates.
   always_comb begin
      // NOTE: every signal gets a default first so no branch can leave it
      // unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      clr_d   = '0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.s_valid) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            cnt_d = '0;
            if (clr_q == CLR_LAST) state_d = ST_INFO;
            else                   clr_d   = clr_q + 1'b1;
         end
         ST_INFO: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == K_LAST) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            addr_d  = P_TOP;
            state_d = ST_PARITY;
         end
         ST_PARITY: begin
            if (addr_q == '0) state_d = ST_TAIL;
            else              addr_d  = addr_q - 1'b1;
         end
         ST_TAIL: begin
            // Counter returns to 0 so the next CLEAR starts from a clean index.
            cnt_d   = '0;
            state_d = bus.s_valid ? ST_CLEAR : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Encoder parity output is registered, so no parity beat appears on
   // the first PARITY cycle; the last one (address 0) lands in TAIL.
   assign par_valid = ((state_q == ST_PARITY) && (addr_q != P_TOP)) ||
                      (state_q == ST_TAIL);

   assign bus.s_ready     = in_info;
   assign bus.m_valid     = sys_valid_q | par_valid;
   assign bus.m_data      = sys_valid_q ? sys_data_q : (par_valid & enc_dout);
   assign bus.m_is_parity = par_valid;
   assign bus.m_last      = (state_q == ST_TAIL);

   assign enc_rst_n     = (state_q inside {ST_INFO, ST_DRAIN, ST_PARITY, ST_TAIL});
   assign enc_din_valid = accept;
   assign enc_din       = accept & bus.s_data;
   assign enc_counter   = cnt_q;
   assign enc_out_addr  = addr_q;
   assign enc_check     = (state_q == ST_PARITY);
   assign busy          = (state_q != ST_IDLE);

   ldpc_len_chk #(
      .K (K)
   ) u_len_chk (
      .accept_i (accept),
      .idx_i    (cnt_q),
      .last_i   (bus.s_last),
      .err_o    (err_frame)
   );

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// Bench for ldpc_enc_ctrl: a cycle table for the start-up sequence, then
// whole frames through a toy parallel encoder (parity[i mod P] ^= bit i)
// whose output is compared with an independent golden XOR model.
module tb_ldpc_enc_ctrl;
   import ldpc_enc_pkg::*;

   localparam int K   = K_DEF;
   localparam int P   = P_DEF;
   localparam int CLR = CLR_CYC_DEF;

   logic  clk = 1'b0;
   logic  rst;
   logic  enc_rst_n, enc_din_valid, enc_din, enc_check, err_frame, busy;
   logic  enc_dout = 1'b0;
   cnt_t  enc_counter;
   addr_t enc_out_addr;

   ldpc_enc_ctrl_if bus ();

   ldpc_enc_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .enc_rst_n     (enc_rst_n),
      .enc_din_valid (enc_din_valid),
      .enc_din       (enc_din),
      .enc_counter   (enc_counter),
      .enc_out_addr  (enc_out_addr),
      .enc_check     (enc_check),
      .enc_dout      (enc_dout),
      .err_frame     (err_frame),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Toy encoder: accumulates by the controller's counter, registered read.
   logic [P-1:0] enc_par;
   always @(posedge clk) begin
      if (!enc_rst_n) enc_par <= '0;
      else if (enc_din_valid && enc_din)
         enc_par[int'(enc_counter) % P] <= ~enc_par[int'(enc_counter) % P];
      enc_dout <= enc_check ? enc_par[enc_out_addr] : 1'b0;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic gold_par(input logic [K-1:0] f, input int addr);
      logic x = 1'b0;
      for (int i = addr; i < K; i += P) x ^= f[i];
      return x;
   endfunction

   // ---------------- stream monitor (called once per cycle) ----------------
   bit           mon_en;
   logic [K-1:0] frm0, frm1;
   int fidx, beat, beats, bit_err, last_cnt, err_cnt, clr_cyc, chk_cyc;
   int cnt_viol, addr_viol, gap_viol, range_viol, follow, max_cnt;
   int prev_cnt, prev_addr;
   bit prev_dv, prev_chk, prev_mlast, last_acc;

   task automatic reset_mon();
      fidx = 0; beat = 0; beats = 0; bit_err = 0; last_cnt = 0; err_cnt = 0;
      clr_cyc = 0; chk_cyc = 0; cnt_viol = 0; addr_viol = 0; gap_viol = 0;
      range_viol = 0; follow = 0; max_cnt = 0;
      prev_cnt = 0; prev_addr = 0; prev_dv = 0; prev_chk = 0; prev_mlast = 0;
   endtask

   task automatic mon();
      logic [K-1:0] f;
      logic         exp;
      if (!mon_en) return;
      f = (fidx == 0) ? frm0 : frm1;
      if (bus.m_valid) begin
         beats++;
         if (beat >= K + P) bit_err++;
         else begin
            exp = (beat < K) ? f[beat] : gold_par(f, P - 1 - (beat - K));
            if (bus.m_data !== exp) bit_err++;
            if (bus.m_is_parity !== (beat >= K)) bit_err++;
            if (bus.m_last !== (beat == K + P - 1)) bit_err++;
         end
         if (bus.m_last) begin
            last_cnt++; beat = 0;
            if (fidx < 1) fidx++;
         end else beat++;
      end else if (bus.m_last) bit_err++;
      if (err_frame) err_cnt++;
      if (busy && !enc_rst_n) clr_cyc++;
      if (enc_check) chk_cyc++;
      if (int'(enc_counter) != prev_cnt &&
          !(enc_counter == 0 || (prev_dv && int'(enc_counter) == prev_cnt + 1))) cnt_viol++;
      if (enc_check && !prev_chk && int'(enc_out_addr) != P - 1) addr_viol++;
      if (enc_check && prev_chk && int'(enc_out_addr) != prev_addr - 1) addr_viol++;
      if (bus.s_ready && bus.m_valid !== prev_dv) gap_viol++;
      if (int'(enc_counter) > K || int'(enc_out_addr) > P - 1) range_viol++;
      if (prev_mlast && busy && !enc_rst_n) follow++;
      if (int'(enc_counter) > max_cnt) max_cnt = int'(enc_counter);
      prev_cnt = int'(enc_counter); prev_addr = int'(enc_out_addr);
      prev_dv = enc_din_valid; prev_chk = enc_check; prev_mlast = bus.m_last;
   endtask

   // One clock: observe at negedge, drive after posedge.
   task automatic cycle();
      @(negedge clk);
      mon();
      last_acc = bus.s_valid & bus.s_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [K-1:0] f, input int gap, input int spur_idx,
                             input bit drop_last, input bit hold, input string tag);
      int n;
      bit tmo = 0;
      for (int i = 0; i < K && !tmo; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = f[i];
         bus.s_last  = ((i == K - 1) && !drop_last) || (i == spur_idx);
         n = 0;
         do begin cycle(); n++; end while (!last_acc && n < 1000);
         if (!last_acc) tmo = 1;
         if (gap > 0) begin
            bus.s_valid = 1'b0;
            repeat (gap) cycle();
         end
      end
      bus.s_valid = hold; bus.s_data = 1'b0; bus.s_last = 1'b0;
      check({tag, "_accept_timeout"}, tmo, 0);
   endtask

   task automatic wait_last(input int target);
      int n = 0;
      while (last_cnt < target && n < 2 * (K + P)) begin cycle(); n++; end
      repeat (2) cycle();
   endtask

   task automatic end_checks(input string tag, input int frames, input int exp_err, input int exp_follow);
      check({tag, "_bits"},      bit_err,    0);
      check({tag, "_beats"},     beats,      frames * (K + P));
      check({tag, "_m_last"},    last_cnt,   frames);
      check({tag, "_err_frame"}, err_cnt,    exp_err);
      check({tag, "_clr_cyc"},   clr_cyc,    frames * CLR);
      check({tag, "_chk_cyc"},   chk_cyc,    frames * P);
      check({tag, "_cnt_step"},  cnt_viol,   0);
      check({tag, "_addr_seq"},  addr_viol,  0);
      check({tag, "_gap_mv"},    gap_viol,   0);
      check({tag, "_range"},     range_viol, 0);
      check({tag, "_cnt_max"},   max_cnt,    K);
      check({tag, "_follow"},    follow,     exp_follow);
   endtask

   task automatic do_reset();
      mon_en = 0;
      bus.s_valid = 1'b0; bus.s_data = 1'b0; bus.s_last = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- start-up table ----------------
   typedef struct {
      logic sv, sd, sl;
      logic ready, rstn, dv, din;
      int   cnt;
      logic mv, md, bsy, err;
   } vec_t;

   function automatic vec_t mk(input logic sv, input logic sd, input logic sl,
                               input logic ready, input logic rstn, input logic dv,
                               input logic din, input int cnt, input logic mv,
                               input logic md, input logic bsy, input logic err);
      vec_t v;
      v.sv = sv; v.sd = sd; v.sl = sl; v.ready = ready; v.rstn = rstn; v.dv = dv;
      v.din = din; v.cnt = cnt; v.mv = mv; v.md = md; v.bsy = bsy; v.err = err;
      return v;
   endfunction

   vec_t tbl [10];
   logic [K-1:0] fz, f1, fr, fa, fb;
   string nm;

   initial begin
      //            sv sd sl  rdy rn dv din cnt  mv md bsy err
      tbl[0] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // IDLE
      tbl[1] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // IDLE, bit not taken
      tbl[2] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0);  // CLEAR 1
      tbl[3] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0);  // CLEAR 2
      tbl[4] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0);  // CLEAR 3
      tbl[5] = mk(1, 1, 0,  1, 1, 1, 1, 0,  0, 0, 1, 0);  // accept idx 0
      tbl[6] = mk(0, 0, 0,  1, 1, 0, 0, 1,  1, 1, 1, 0);  // gap, echo bit 0
      tbl[7] = mk(1, 0, 1,  1, 1, 1, 0, 1,  0, 0, 1, 1);  // idx 1, early last
      tbl[8] = mk(1, 1, 0,  1, 1, 1, 1, 2,  1, 0, 1, 0);  // idx 2
      tbl[9] = mk(0, 0, 0,  1, 1, 0, 0, 3,  1, 1, 1, 0);  // gap, echo bit 2

      mon_en = 0;
      reset_mon();
      bus.s_valid = 1'b0; bus.s_data = 1'b0; bus.s_last = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_enc_rst_n", enc_rst_n,    0);
      check("rst_counter",   enc_counter,  0);
      check("rst_out_addr",  enc_out_addr, 0);
      check("rst_busy",      busy,         0);
      check("rst_s_ready",   bus.s_ready,  0);
      check("rst_m_valid",   bus.m_valid,  0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         bus.s_valid = tbl[i].sv; bus.s_data = tbl[i].sd; bus.s_last = tbl[i].sl;
         @(negedge clk);
         nm = $sformatf("v%0d_", i);
         check({nm, "s_ready"},   bus.s_ready,   tbl[i].ready);
         check({nm, "enc_rst_n"}, enc_rst_n,     tbl[i].rstn);
         check({nm, "din_valid"}, enc_din_valid, tbl[i].dv);
         check({nm, "din"},       enc_din,       tbl[i].din);
         check({nm, "counter"},   enc_counter,   tbl[i].cnt);
         check({nm, "m_valid"},   bus.m_valid,   tbl[i].mv);
         check({nm, "m_data"},    bus.m_data,    tbl[i].md);
         check({nm, "busy"},      busy,          tbl[i].bsy);
         check({nm, "err_frame"}, err_frame,     tbl[i].err);
         @(posedge clk);
         #1;
      end

      fz = '0;
      f1 = '0; f1[0] = 1'b1;
      for (int i = 0; i < K; i++) begin
         fr[i] = 1'($urandom_range(0, 1));
         fa[i] = 1'($urandom_range(0, 1));
         fb[i] = 1'($urandom_range(0, 1));
      end

      // All-zero frame, s_valid held high.
      do_reset(); reset_mon(); frm0 = fz; mon_en = 1;
      send_frame(fz, 0, -1, 0, 0, "zero"); wait_last(1);
      end_checks("zero", 1, 0, 0);

      // Single 1 at index 0.
      do_reset(); reset_mon(); frm0 = f1; mon_en = 1;
      send_frame(f1, 0, -1, 0, 0, "one"); wait_last(1);
      end_checks("one", 1, 0, 0);

      // Random frame continuous, then the same frame with 2-cycle gaps.
      do_reset(); reset_mon(); frm0 = fr; mon_en = 1;
      send_frame(fr, 0, -1, 0, 0, "rnd"); wait_last(1);
      end_checks("rnd", 1, 0, 0);
      reset_mon();
      send_frame(fr, 2, -1, 0, 0, "gap"); wait_last(1);
      end_checks("gap", 1, 0, 0);

      // Spurious s_last at 100, missing at K-1.
      reset_mon(); frm0 = fa;
      send_frame(fa, 0, 100, 1, 0, "slast"); wait_last(1);
      end_checks("slast", 1, 2, 0);

      // Asynchronous reset in the parity phase.
      reset_mon(); frm0 = fb;
      send_frame(fb, 0, -1, 0, 0, "mid");
      begin
         int n = 0;
         while (!(enc_check && enc_out_addr == 200) && n < 2 * P) begin cycle(); n++; end
         check("mid_reach_addr200", enc_out_addr, 200);
      end
      #2 rst = 1'b1;
      #1;
      check("mid_enc_rst_n", enc_rst_n,       0);
      check("mid_counter",   enc_counter,     0);
      check("mid_out_addr",  enc_out_addr,    0);
      check("mid_check",     enc_check,       0);
      check("mid_m_valid",   bus.m_valid,     0);
      check("mid_m_data",    bus.m_data,      0);
      check("mid_m_parity",  bus.m_is_parity, 0);
      check("mid_m_last",    bus.m_last,      0);
      check("mid_busy",      busy,            0);
      check("mid_no_last",   last_cnt,        0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      reset_mon(); frm0 = fa;
      repeat (3) cycle();
      send_frame(fa, 0, -1, 0, 0, "post"); wait_last(1);
      end_checks("post", 1, 0, 0);

      // Back-to-back frames with s_valid held across TAIL.
      do_reset(); reset_mon(); frm0 = fa; frm1 = fb; mon_en = 1;
      send_frame(fa, 0, -1, 0, 1, "b2b_a");
      send_frame(fb, 0, -1, 0, 0, "b2b_b");
      wait_last(2);
      end_checks("b2b", 2, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
